// File: rtl/clk_step_ctrl.sv
// ---------------------------------------------------------------------------
// clk_step_ctrl
//   Single-clock step sequencer for the lab clock-source datapath. Produces a
//   one-cycle clock enable (step_en) that downstream latches/counters qualify
//   on clk. Free-run mode steps on a divider tick; manual mode emits a
//   debounced burst of steps per button press; halt freezes stepping.
//
// Parameters
//   DIV_BIT    tick when clkdiv[DIV_BIT:0] is all ones (period 2^(DIV_BIT+1))
//   DB_CYCLES  consecutive stable cycles needed to accept a button change
//   BURST_W    width of burst_len
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   mode_run   in   1 = free-run, 0 = manual (asynchronous)
//   btn        in   raw pushbutton, active-high, bouncy (asynchronous)
//   burst_len  in   steps per press, 0 behaves as 1, sampled on press
//   halt       in   synchronous freeze request (level)
//   clkdiv     out  free-running 32-bit divider count
//   step_en    out  one-cycle advance enable
//   busy       out  high while a burst is in progress
//   state      out  FSM state code (LEDs/debug)
//   step_cnt   out  total steps issued, wraps modulo 2^16
// ---------------------------------------------------------------------------
module clk_step_ctrl #(
    parameter int DIV_BIT   = 26,
    parameter int DB_CYCLES = 1_000_000,
    parameter int BURST_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode_run,
    input  logic               btn,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               halt,
    output logic [31:0]        clkdiv,
    output logic               step_en,
    output logic               busy,
    output logic [2:0]         state,
    output logic [15:0]        step_cnt
);

    localparam logic [2:0] ST_MANUAL  = 3'd0;
    localparam logic [2:0] ST_BURST   = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    // The counter only ever needs to reach DB_CYCLES-1 before it clears.
    localparam int              DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic               btn_p0, btn_s;
    logic               mode_p0, mode_s;
    logic [DB_W-1:0]    db_cnt;
    logic               btn_db, btn_db_d;
    logic               press;
    logic               tick;
    logic [BURST_W-1:0] rem, rem_nxt;
    logic [2:0]         state_nxt;

    // A zero-length burst still issues one step.
    function automatic logic [BURST_W-1:0] clamp_burst(input logic [BURST_W-1:0] len);
        return (len == '0) ? BURST_W'(1) : len;
    endfunction

    assign tick = &clkdiv[DIV_BIT:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv <= '0;
        end else begin
            clkdiv <= clkdiv + 32'd1;
        end
    end

    // Stage p0 -> s: two-flop synchronisers for the asynchronous inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_p0  <= 1'b0;
            btn_s   <= 1'b0;
            mode_p0 <= 1'b0;
            mode_s  <= 1'b0;
        end else begin
            btn_p0  <= btn;
            btn_s   <= btn_p0;
            mode_p0 <= mode_run;
            mode_s  <= mode_p0;
        end
    end

    // Stage s -> db: accept a new button level only after DB_CYCLES
    // consecutive cycles of disagreement with the current debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press = btn_db & ~btn_db_d;

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        if (halt) begin
            // Freeze wins over everything, including a coincident press.
            state_nxt = ST_HALT;
            rem_nxt   = '0;
        end else begin
            case (state)
                ST_MANUAL: begin
                    if (mode_s) begin
                        state_nxt = ST_RUN;
                    end else if (press) begin
                        rem_nxt   = clamp_burst(burst_len);
                        state_nxt = ST_BURST;
                    end
                end
                ST_BURST: begin
                    rem_nxt = rem - BURST_W'(1);
                    if (rem == BURST_W'(1)) begin
                        state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Hold here until the button is let go so one press
                    // cannot retrigger.
                    if (!btn_db) begin
                        state_nxt = mode_s ? ST_RUN : ST_MANUAL;
                    end
                end
                ST_RUN: begin
                    if (!mode_s) begin
                        state_nxt = ST_MANUAL;
                    end
                end
                ST_HALT: begin
                    if (!btn_db) begin
                        state_nxt = mode_s ? ST_RUN : ST_MANUAL;
                    end
                end
                default: begin
                    state_nxt = ST_MANUAL;
                    rem_nxt   = '0;
                end
            endcase
        end
    end

    // Stage db -> fsm: registered state and remaining-step count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_MANUAL;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Decoded purely from registers so no input reaches step_en combinationally.
    assign step_en = (state == ST_BURST) | ((state == ST_RUN) & tick);
    assign busy    = (state == ST_BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (step_en) begin
            step_cnt <= step_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_clk_step_ctrl.sv
module tb_clk_step_ctrl;

    localparam int DIV_BIT   = 3;
    localparam int DB_CYCLES = 4;
    localparam int BURST_W   = 8;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               mode_run  = 1'b0;
    logic               btn       = 1'b0;
    logic [BURST_W-1:0] burst_len = '0;
    logic               halt      = 1'b0;
    logic [31:0]        clkdiv;
    logic               step_en;
    logic               busy;
    logic [2:0]         state;
    logic [15:0]        step_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int steps_seen = 0;

    clk_step_ctrl #(
        .DIV_BIT  (DIV_BIT),
        .DB_CYCLES(DB_CYCLES),
        .BURST_W  (BURST_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_run (mode_run),
        .btn      (btn),
        .burst_len(burst_len),
        .halt     (halt),
        .clkdiv   (clkdiv),
        .step_en  (step_en),
        .busy     (busy),
        .state    (state),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (step_en) steps_seen <= steps_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        btn      = 1'b0;
        halt     = 1'b0;
        mode_run = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int first, last, cnt, prev, base, seen, run, maxrun;

        // 1: reset state and clkdiv counting
        cyc(3);
        chk("rst_clkdiv", clkdiv, 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_step_en", 32'(step_en), 0);
        chk("rst_step_cnt", 32'(step_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        #1 chk("t1_clkdiv0", clkdiv, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("t1_clkdiv%0d", i), clkdiv, 32'(i));
        end
        chk("t1_step_en", 32'(step_en), 0);

        // 2: manual burst of 3
        do_reset();
        burst_len = 8'd3;
        btn = 1'b1;
        first = -1; last = -1; cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (step_en) begin
                if (first < 0) first = k;
                last = k;
                cnt++;
            end
            if (k == 8) chk("t2_busy", 32'(busy), 1);
        end
        chk("t2_first", 32'(first), 7);
        chk("t2_count", 32'(cnt), 3);
        chk("t2_contig", 32'(last - first + 1), 3);
        chk("t2_step_cnt", 32'(step_cnt), 3);
        chk("t2_state_rel", 32'(state), 2);
        btn = 1'b0;
        cyc(5);
        chk("t2_state_hold", 32'(state), 2);
        cyc(3);
        chk("t2_state_man", 32'(state), 0);

        // 3: short glitches never pass the debouncer
        do_reset();
        base = steps_seen;
        begin
            int hi[5] = '{1, 3, 2, 3, 1};
            int lo[5] = '{3, 1, 2, 3, 1};
            for (int i = 0; i < 5; i++) begin
                btn = 1'b1; cyc(hi[i]);
                btn = 1'b0; cyc(lo[i]);
            end
        end
        cyc(10);
        chk("t3_steps", 32'(steps_seen - base), 0);
        chk("t3_step_cnt", 32'(step_cnt), 0);
        chk("t3_state", 32'(state), 0);

        // 4: free-run stepping on divider tick, then exit
        do_reset();
        mode_run = 1'b1;
        cyc(4);
        chk("t4_state_run", 32'(state), 3);
        base = steps_seen;
        prev = -1; cnt = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (step_en) begin
                chk("t4_tick_nib", 32'(clkdiv[3:0]), 15);
                if (prev >= 0) chk("t4_period", 32'(k - prev), 16);
                prev = k;
                cnt++;
            end
        end
        chk("t4_count", 32'(cnt), 4);
        mode_run = 1'b0;
        cyc(3);
        chk("t4_state_man", 32'(state), 0);
        base = steps_seen;
        cyc(20);
        chk("t4_no_steps", 32'(steps_seen - base), 0);

        // 5: halt mid-burst
        do_reset();
        burst_len = 8'd5;
        btn = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            @(negedge clk);
            if (step_en) seen++;
        end
        chk("t5_reach2", 32'(seen), 2);
        halt = 1'b1;
        @(negedge clk);
        chk("t5_step_en", 32'(step_en), 0);
        chk("t5_state_halt", 32'(state), 4);
        chk("t5_step_cnt", 32'(step_cnt), 2);
        btn = 1'b0;
        cyc(10);
        halt = 1'b0;
        cyc(3);
        chk("t5_state_man", 32'(state), 0);
        cyc(20);
        chk("t5_step_cnt_end", 32'(step_cnt), 2);

        // press coinciding with halt is ignored
        do_reset();
        burst_len = 8'd4;
        btn = 1'b1;
        cyc(6);
        halt = 1'b1;
        cyc(3);
        chk("hp_state_halt", 32'(state), 4);
        btn = 1'b0;
        cyc(10);
        halt = 1'b0;
        cyc(3);
        chk("hp_state_man", 32'(state), 0);
        chk("hp_step_cnt", 32'(step_cnt), 0);

        // 6a: burst_len=0 gives exactly one step
        do_reset();
        burst_len = 8'd0;
        base = steps_seen;
        btn = 1'b1;
        cyc(12);
        btn = 1'b0;
        cyc(12);
        chk("t6_len0_cnt", 32'(step_cnt), 1);
        chk("t6_len0_seen", 32'(steps_seen - base), 1);
        chk("t6_len0_state", 32'(state), 0);

        // 6b: reset mid-burst
        do_reset();
        burst_len = 8'd8;
        btn = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && seen < 3; k++) begin
            @(negedge clk);
            if (step_en) seen++;
        end
        chk("t6_reach3", 32'(seen), 3);
        rst_n = 1'b0;
        btn = 1'b0;
        #1;
        chk("t6_rst_cnt", 32'(step_cnt), 0);
        chk("t6_rst_state", 32'(state), 0);
        chk("t6_rst_step_en", 32'(step_en), 0);
        chk("t6_rst_clkdiv", clkdiv, 0);
        cyc(2);
        rst_n = 1'b1;
        base = steps_seen;
        cyc(20);
        chk("t6_post_seen", 32'(steps_seen - base), 0);
        chk("t6_post_cnt", 32'(step_cnt), 0);

        // 255-step burst, back to back
        do_reset();
        burst_len = 8'd255;
        btn = 1'b1;
        cnt = 0; run = 0; maxrun = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (step_en) begin
                cnt++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        btn = 1'b0;
        chk("b255_count", 32'(cnt), 255);
        chk("b255_run", 32'(maxrun), 255);
        chk("b255_step_cnt", 32'(step_cnt), 255);
        cyc(10);
        chk("b255_state", 32'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
